sram_req_adapter: RTL and testbench

Valid/ready front-end that sits directly upstream of a single-ported `mp_sram`-style macro (fixed read latency 1 or 2, no backpressure). It converts a request stream into the SRAM's `req/we/addr/wdata/be` strobes. It also collects read data into a small response FIFO, so a consumer may stall the response channel without losing data. A credit count bounds outstanding reads so the FIFO can never overflow.

---
 rtl/sram_req_adapter.sv | 95 +++++++++
 tb/tb_sram_req_adapter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_adapter.sv
// Valid/ready front-end for a single-ported SRAM macro with fixed read latency.
// Read data lands in a small response FIFO; credits bound outstanding reads so it never overflows.
module sram_req_adapter #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RespDepth = 3,
  localparam int unsigned AddrWidth = $clog2(NumWords),
  localparam int unsigned BeWidth   = (DataWidth + 7) / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned CntWidth = $clog2(RespDepth + 1);
  localparam int unsigned PtrWidth = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam logic [CntWidth-1:0] Depth   = CntWidth'(RespDepth);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(RespDepth - 1);

  logic [Latency-1:0]   inflight_q;
  logic [CntWidth-1:0]  inflight_cnt;
  logic [CntWidth-1:0]  fifo_count_q;
  logic [CntWidth:0]    used;
  logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DataWidth-1:0] mem_q [RespDepth];
  logic                 accept, rd_accept, push, pop;

  // Credits count both reads still inside the SRAM pipeline and entries already buffered.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional logic so no latch is inferred.
    inflight_cnt = '0;
    for (int i = 0; i < int'(Latency); i++) begin
      inflight_cnt = inflight_cnt + CntWidth'(inflight_q[i]);
    end
    used = {1'b0, inflight_cnt} + {1'b0, fifo_count_q};
  end

  assign req_ready_o = ~rst_i & (used < {1'b0, Depth});
  assign accept      = req_valid_i & req_ready_o;
  assign rd_accept   = accept & ~req_we_i;
  assign push        = inflight_q[Latency-1];
  assign pop         = rsp_valid_o & rsp_ready_i;

  assign sram_req_o   = accept;
  assign sram_we_o    = accept & req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_be_o    = req_be_i;

  assign rsp_valid_o = ~rst_i & (fifo_count_q != '0);
  assign rsp_rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      inflight_q   <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      inflight_q <= (inflight_q << 1) | Latency'(rd_accept);
      if (push) wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + 1'b1;
        2'b01:   fifo_count_q <= fifo_count_q - 1'b1;
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  // NOTE: the data storage has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= sram_rdata_i;
  end

  // The credit limit makes a push into a full FIFO unreachable.
  overflow_a: assert property (@(posedge clk_i) disable iff (rst_i) push |-> (fifo_count_q != Depth));

endmodule

// File: tb/tb_sram_req_adapter.sv
// Bench for sram_req_adapter: one instance at Latency=1/RespDepth=3, one at Latency=2/RespDepth=4,
// each behind a behavioural SRAM; read data is scoreboarded against a reference memory.
module tb_sram_req_adapter;
  localparam int DW = 64;
  localparam int NW = 1024;
  localparam int AW = 10;
  localparam int BW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 1 (Latency 1, RespDepth 3)
  logic          req_valid, req_ready, req_we, rsp_valid, rsp_ready;
  logic [AW-1:0] req_addr, sram_addr;
  logic [DW-1:0] req_wdata, rsp_rdata, sram_wdata, sram_rdata;
  logic [BW-1:0] req_be, sram_be;
  logic          sram_req, sram_we;

  // Instance 2 (Latency 2, RespDepth 4)
  logic          req_valid2, req_ready2, req_we2, rsp_valid2, rsp_ready2;
  logic [AW-1:0] req_addr2, sram_addr2;
  logic [DW-1:0] req_wdata2, rsp_rdata2, sram_wdata2, sram_rdata2;
  logic [BW-1:0] req_be2, sram_be2;
  logic          sram_req2, sram_we2;

  sram_req_adapter #(.DataWidth(DW), .NumWords(NW), .Latency(1), .RespDepth(3)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  sram_req_adapter #(.DataWidth(DW), .NumWords(NW), .Latency(2), .RespDepth(4)) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid2), .req_ready_o(req_ready2), .req_we_i(req_we2),
    .req_addr_i(req_addr2), .req_wdata_i(req_wdata2), .req_be_i(req_be2),
    .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2), .rsp_rdata_o(rsp_rdata2),
    .sram_req_o(sram_req2), .sram_we_o(sram_we2), .sram_addr_o(sram_addr2),
    .sram_wdata_o(sram_wdata2), .sram_be_o(sram_be2), .sram_rdata_i(sram_rdata2)
  );

  function automatic logic [DW-1:0] init_word(int i);
    return {16'hA5A5, 16'(i), 32'(i * 3 + 1)};
  endfunction

  // Behavioural SRAMs; read data is X in any cycle where it is not valid.
  logic [DW-1:0] mem1 [NW];
  logic [DW-1:0] mem2 [NW];
  logic [DW-1:0] rd1, rd2a, rd2b;
  logic [DW-1:0] ref1 [NW];
  logic [DW-1:0] ref2 [NW];

  always @(posedge clk) begin
    rd1 <= 'x;
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++) if (sram_be[b]) mem1[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        rd1 <= mem1[sram_addr];
      end
    end
  end
  assign sram_rdata = rd1;

  always @(posedge clk) begin
    rd2a <= 'x;
    rd2b <= rd2a;
    if (sram_req2) begin
      if (sram_we2) begin
        for (int b = 0; b < BW; b++) if (sram_be2[b]) mem2[sram_addr2][8*b +: 8] <= sram_wdata2[8*b +: 8];
      end else begin
        rd2a <= mem2[sram_addr2];
      end
    end
  end
  assign sram_rdata2 = rd2b;

  // Scoreboards
  logic [DW-1:0] q1 [$];
  logic [DW-1:0] q2 [$];
  int rsp1_cnt = 0, rsp1_first = 0, rsp1_last = 0;
  int acc2_reads = 0, rsp2_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
    end else begin
      checks++;
      if (req_valid && req_ready) begin
        if (sram_req !== 1'b1 || sram_we !== req_we || sram_addr !== req_addr ||
            (req_we && (sram_wdata !== req_wdata || sram_be !== req_be))) begin
          failures++;
          $display("FAIL sram_passthru1: got req=%b we=%b addr=%h expected req=1 we=%b addr=%h",
                   sram_req, sram_we, sram_addr, req_we, req_addr);
        end
        if (req_we) begin
          for (int b = 0; b < BW; b++) if (req_be[b]) ref1[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
        end else begin
          q1.push_back(ref1[req_addr]);
        end
      end else if (sram_req !== 1'b0 || sram_we !== 1'b0) begin
        failures++;
        $display("FAIL sram_idle1: got req=%b we=%b expected req=0 we=0", sram_req, sram_we);
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected1: got data=%h expected no response", rsp_rdata);
        end else begin
          logic [DW-1:0] exp_d;
          exp_d = q1.pop_front();
          if (rsp_rdata !== exp_d) begin
            failures++;
            $display("FAIL rsp_data1: got %h expected %h", rsp_rdata, exp_d);
          end
        end
        if (rsp1_cnt == 0) rsp1_first = cyc;
        rsp1_last = cyc;
        rsp1_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q2.delete();
    end else begin
      checks++;
      if (q2.size() > 4) begin
        failures++;
        $display("FAIL used_bound2: got %0d outstanding expected at most 4", q2.size());
      end
      if (req_valid2 && req_ready2) begin
        if (req_we2) begin
          for (int b = 0; b < BW; b++) if (req_be2[b]) ref2[req_addr2][8*b +: 8] = req_wdata2[8*b +: 8];
        end else begin
          q2.push_back(ref2[req_addr2]);
          acc2_reads++;
        end
      end
      if (rsp_valid2 && rsp_ready2) begin
        checks++;
        rsp2_cnt++;
        if (q2.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected2: got data=%h expected no response", rsp_rdata2);
        end else begin
          logic [DW-1:0] exp_d;
          exp_d = q2.pop_front();
          if (rsp_rdata2 !== exp_d) begin
            failures++;
            $display("FAIL rsp_data2: got %h expected %h", rsp_rdata2, exp_d);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = '0;
    req_valid2 = 1'b1; req_we2 = 1'b0; req_addr2 = '0;
    step();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || sram_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%b sram_req=%b rsp_valid=%b ready2=%b expected all 0",
               req_ready, sram_req, rsp_valid, req_ready2);
    end
    step();
    rst = 1'b0; req_valid = 1'b0; req_valid2 = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || req_ready2 !== 1'b1 || rsp_valid2 !== 1'b0) begin
      failures++;
      $display("FAIL after_reset: got ready=%b rsp_valid=%b ready2=%b rsp_valid2=%b expected 1 0 1 0",
               req_ready, rsp_valid, req_ready2, rsp_valid2);
    end
    step();
  endtask

  task automatic test_single_read();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd5;
    req_wdata = 64'hDEADBEEF_00000001; req_be = 8'hFF;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL single_wr_accept: got ready=%b expected 1", req_ready); end
    step();
    req_we = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL single_rd_accept: got ready=%b expected 1", req_ready); end
    step();
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early: got rsp_valid=%b expected 0 at c+1", rsp_valid); end
    step();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hDEADBEEF_00000001) begin
      failures++;
      $display("FAIL single_rsp: got valid=%b data=%h expected valid=1 data=deadbeef00000001", rsp_valid, rsp_rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    rsp1_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(i);
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b expected 1 at read %0d", req_ready, i); end
      step();
    end
    req_valid = 1'b0;
    for (int k = 0; k < 8 && rsp1_cnt < 16; k++) step();
    checks++;
    if (rsp1_cnt != 16 || rsp1_last - rsp1_first != 15) begin
      failures++;
      $display("FAIL b2b_rsp: got %0d responses over %0d cycles expected 16 over 15",
               rsp1_cnt, rsp1_last - rsp1_first);
    end
  endtask

  task automatic test_stall();
    int acc = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(20 + acc);
      @(negedge clk);
      if (req_ready === 1'b1) acc++;
      step();
    end
    checks++;
    if (acc != 3) begin failures++; $display("FAIL stall_count: got %0d accepted expected 3", acc); end
    req_we = 1'b1; req_addr = 10'd30; req_wdata = '1; req_be = 8'hFF;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || sram_req !== 1'b0 || sram_we !== 1'b0) begin
      failures++;
      $display("FAIL stall_write: got ready=%b sram_req=%b sram_we=%b expected 0 0 0", req_ready, sram_req, sram_we);
    end
    step();
    req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_first_pop: got rsp_valid=%b ready=%b expected 1 0", rsp_valid, req_ready);
    end
    step();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL stall_credit: got ready=%b expected 1", req_ready); end
    step();
    for (int k = 0; k < 8 && q1.size() != 0; k++) step();
    checks++;
    if (q1.size() != 0) begin failures++; $display("FAIL stall_drain: got %0d pending expected 0", q1.size()); end
  endtask

  task automatic test_byte_enable();
    bit seen = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = 10'd7;
      req_we    = (i < 2);
      req_wdata = (i == 0) ? '1 : '0;
      req_be    = (i == 0) ? 8'hFF : 8'h0F;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL be_accept: got ready=%b expected 1 at step %0d", req_ready, i); end
      step();
    end
    req_valid = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (rsp_rdata !== 64'hFFFFFFFF_00000000) begin
          failures++;
          $display("FAIL be_data: got %h expected ffffffff00000000", rsp_rdata);
        end
      end
      step();
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL be_timeout: got no response expected one within 6 cycles");
    end
  endtask

  task automatic test_latency2_random();
    acc2_reads = 0; rsp2_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      req_valid2 = ($urandom_range(0, 3) != 0);
      req_we2    = ($urandom_range(0, 3) == 0);
      req_addr2  = AW'($urandom_range(0, 31));
      req_wdata2 = {$urandom, $urandom};
      req_be2    = BW'($urandom_range(0, 255));
      rsp_ready2 = ($urandom_range(0, 1) == 1);
      step();
    end
    req_valid2 = 1'b0; rsp_ready2 = 1'b1;
    for (int k = 0; k < 20 && q2.size() != 0; k++) step();
    checks++;
    if (q2.size() != 0 || rsp2_cnt != acc2_reads || acc2_reads == 0) begin
      failures++;
      $display("FAIL lat2_balance: got %0d responses for %0d reads, %0d pending expected equal and 0 pending",
               rsp2_cnt, acc2_reads, q2.size());
    end
  endtask

  task automatic test_reset_mid_op();
    rsp_ready2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid2 = 1'b1; req_we2 = 1'b0; req_addr2 = AW'(40 + i);
      @(negedge clk);
      checks++;
      if (req_ready2 !== 1'b1) begin failures++; $display("FAIL midrst_accept: got ready2=%b expected 1 at read %0d", req_ready2, i); end
      step();
    end
    rst = 1'b1; req_addr2 = 10'd43;
    @(negedge clk);
    checks++;
    if (req_ready2 !== 1'b0 || sram_req2 !== 1'b0 || rsp_valid2 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_during: got ready2=%b sram_req2=%b rsp_valid2=%b expected 0 0 0",
               req_ready2, sram_req2, rsp_valid2);
    end
    step();
    rst = 1'b0; req_valid2 = 1'b0; rsp_ready2 = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready2 !== 1'b1 || rsp_valid2 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_after: got ready2=%b rsp_valid2=%b expected 1 0", req_ready2, rsp_valid2);
    end
    step();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid2 !== 1'b0) begin failures++; $display("FAIL midrst_stale: got rsp_valid2=%b expected 0", rsp_valid2); end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      mem1[i] = init_word(i); ref1[i] = init_word(i);
      mem2[i] = init_word(i); ref2[i] = init_word(i);
    end
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = '0; req_wdata2 = '0; req_be2 = '0; rsp_ready2 = 1'b0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_stall();
    test_byte_enable();
    test_latency2_random();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
